instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, first byte address written after reset or restart.
REQ-002 Parameter MAX_WORDS, default 1024, number of words accepted before the block reports full; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  field bundle valid.
REQ-006 in_ready  output  1  block accepts the bundle this cycle.
REQ-007 opcode  input  7; rd, rs1, rs2  input  5 each; funct3  input  3; funct7  input  7: instruction fields.
REQ-008 imm  input  32  full signed immediate value; B/J values are byte offsets.
REQ-009 restart  input  1  synchronous rewind of the address counter.
REQ-010 out_valid  output  1  and out_ready  input  1: encoded-word handshake.
REQ-011 instr  output  32  encoded RV32I word.
REQ-012 addr  output  32  byte address for instr.
REQ-013 range_err  output  1  imm not representable; fmt_err  output  1  unsupported opcode.
REQ-014 full  output  1  MAX_WORDS words accepted since reset or restart.

Function
REQ-015 Formats: R 0110011; I 0000011, 0010011, 1100111; S 0100011; B 1100011; U 0110111, 0010111; J 1101111. Fields are placed per the RV32I base formats.
REQ-016 Unused fields are ignored; funct7 is used only by R.
REQ-017 Range rules: I/S need imm[31:11] all equal; B needs imm[31:12] all equal and imm[0]=0; J needs imm[31:20] all equal and imm[0]=0; U needs imm[11:0]=0; R has no check.
REQ-018 On a range violation, instr carries the truncated bits and range_err=1 for that word; on legal input, range_err=0.
REQ-019 An unsupported opcode produces instr=32'h0000_0013 (NOP) with fmt_err=1 and range_err=0.
REQ-020 in_ready = !restart && !full && (!out_valid || out_ready); it is combinational.
REQ-021 An accept (in_valid && in_ready) loads instr, addr, range_err and fmt_err into the output register; out_valid=1 on the next cycle; latency is 1 cycle.
REQ-022 While out_valid && !out_ready, instr, addr and the error flags stay stable.
REQ-023 An accept in the same cycle as the output handshake replaces the output word with no bubble.
REQ-024 The address counter starts at BASE_ADDR and increments by 4 per accept, wrapping modulo 2^32.
REQ-025 FSM states: EMPTY (no accepts yet), FILLING, FULL.
REQ-026 FSM transitions:
- EMPTY -> FILLING on the first accept.
- FILLING -> FULL on the accept that brings the word count to MAX_WORDS.
- Any state -> EMPTY on restart.
REQ-027 full=1 exactly in state FULL.
REQ-028 Restart sets the counter to BASE_ADDR and the count to 0; a pending output word is preserved and can still drain.
REQ-029 Restart in the same cycle as in_valid means no accept, because restart wins.
REQ-030 out_valid drops only on the output handshake with no new accept.

Reset
REQ-031 While rst_n=0, regardless of clk:
- out_valid=0, instr=0, addr=BASE_ADDR, range_err=0, fmt_err=0, full=0;
- word count=0, state=EMPTY.
REQ-032 Reset asserted mid-transfer discards the pending word.
REQ-033 in_ready may assert in the first cycle after rst_n deasserts.

Verification
REQ-034 Bench: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_valid=1, instr=0x0050_0093, addr=0x0, errors 0.
REQ-035 Bench: opcode=0100011, funct3=010, rs1=1, rs2=2, imm=8 -> instr=0x0020_A423; next accept addr=0x4.
REQ-036 Bench: opcode=1100011, funct3=0, rs1=rs2=0, imm=-4 -> instr=0xFE00_0EE3. Same with imm=4096 -> range_err=1.
REQ-037 Bench: opcode=0010011, rd=1, imm=4096 -> instr=0x0000_0093, range_err=1. Opcode=1111111 -> instr=0x0000_0013, fmt_err=1.
REQ-038 Bench: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instr/addr stable, no counter advance. Then out_ready=1 with continuous in_valid -> one word per cycle, no bubble.
REQ-039 Bench: MAX_WORDS=4, 4 accepts -> full=1, in_ready=0. Restart -> full=0, next word addr=BASE_ADDR. rst_n pulse with out_valid=1 -> out_valid=0 immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word
// with a byte address, range/format flags and a word-count limit.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        restart,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        range_err,
    output logic        fmt_err,
    output logic        full
);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } state_t;

    localparam logic [16:0] MAXC = 17'(MAX_WORDS);

    state_t      state;
    logic [16:0] count;
    logic [16:0] count_inc;
    logic [31:0] next_addr;

    logic        is_r;
    logic        is_i;
    logic        is_s;
    logic        is_b;
    logic        is_u;
    logic        is_j;
    logic        i_ok;
    logic        b_ok;
    logic        j_ok;
    logic        u_ok;

    logic [31:0] enc;
    logic        enc_re;
    logic        enc_fe;
    logic        accept;
    logic        drain;

    assign is_r = opcode == 7'b0110011;
    assign is_i = opcode == 7'b0000011
               || opcode == 7'b0010011
               || opcode == 7'b1100111;
    assign is_s = opcode == 7'b0100011;
    assign is_b = opcode == 7'b1100011;
    assign is_u = opcode == 7'b0110111
               || opcode == 7'b0010111;
    assign is_j = opcode == 7'b1101111;

    // Sign-extension checks: the dropped high bits must all match.
    assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    assign u_ok = ~(|imm[11:0]);

    always_comb begin
        enc    = 32'h0000_0013;
        enc_re = 1'b0;
        enc_fe = 1'b0;
        unique case (1'b1)
            is_r: begin
                enc = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            is_i: begin
                enc    = {imm[11:0], rs1, funct3, rd, opcode};
                enc_re = ~i_ok;
            end
            is_s: begin
                enc    = {imm[11:5], rs2, rs1, funct3,
                          imm[4:0], opcode};
                enc_re = ~i_ok;
            end
            is_b: begin
                enc    = {imm[12], imm[10:5], rs2, rs1, funct3,
                          imm[4:1], imm[11], opcode};
                enc_re = ~b_ok;
            end
            is_u: begin
                enc    = {imm[31:12], rd, opcode};
                enc_re = ~u_ok;
            end
            is_j: begin
                enc    = {imm[20], imm[10:1], imm[11],
                          imm[19:12], rd, opcode};
                enc_re = ~j_ok;
            end
            default: begin
                enc_fe = 1'b1;
            end
        endcase
    end

    assign in_ready  = !restart && !full && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign count_inc = count + 17'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= 32'h0;
            addr      <= BASE_ADDR;
            range_err <= 1'b0;
            fmt_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            instr     <= enc;
            addr      <= next_addr;
            range_err <= enc_re;
            fmt_err   <= enc_fe;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            count     <= 17'd0;
            next_addr <= BASE_ADDR;
            full      <= 1'b0;
        end else if (restart) begin
            state     <= EMPTY;
            count     <= 17'd0;
            next_addr <= BASE_ADDR;
            full      <= 1'b0;
        end else if (accept) begin
            count     <= count_inc;
            next_addr <= next_addr + 32'd4;
            unique case (state)
                EMPTY, FILLING: begin
                    if (count_inc == MAXC) begin
                        state <= FULL;
                        full  <= 1'b1;
                    end else begin
                        state <= FILLING;
                    end
                end
                default: begin
                    state <= FULL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed literal cases plus random traffic
// compared each cycle against an arithmetic reference model.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        restart;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        range_err;
    logic        fmt_err;
    logic        full;

    instr_encoder #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .restart  (restart),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .instr    (instr),
        .addr     (addr),
        .range_err(range_err),
        .fmt_err  (fmt_err),
        .full     (full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_addr;
    logic        m_re;
    logic        m_fe;
    int          m_count;
    logic [31:0] m_next;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit fits(input logic [31:0] v, input int bits);
        int s;
        s = $signed(v);
        return s >= -(1 << (bits - 1)) && s < (1 << (bits - 1));
    endfunction

    function automatic logic [31:0] model_enc(output logic re,
                                              output logic fe);
        logic [31:0] base;
        logic [31:0] w;
        base = (32'(rs1) << 15) | (32'(funct3) << 12) | 32'(opcode);
        re = 1'b0;
        fe = 1'b0;
        case (opcode)
            7'b0110011: w = base | (32'(funct7) << 25)
                          | (32'(rs2) << 20) | (32'(rd) << 7);
            7'b0000011, 7'b0010011, 7'b1100111: begin
                w  = base | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
                re = !fits(imm, 12);
            end
            7'b0100011: begin
                w  = base | (((imm >> 5) & 32'h7F) << 25)
                   | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
                re = !fits(imm, 12);
            end
            7'b1100011: begin
                w  = base | (((imm >> 12) & 32'h1) << 31)
                   | (((imm >> 5) & 32'h3F) << 25)
                   | (32'(rs2) << 20)
                   | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7);
                re = !fits(imm, 13) || imm[0];
            end
            7'b0110111, 7'b0010111: begin
                w  = (imm & 32'hFFFF_F000) | (32'(rd) << 7)
                   | 32'(opcode);
                re = (imm & 32'hFFF) != 0;
            end
            7'b1101111: begin
                w  = (((imm >> 20) & 32'h1) << 31)
                   | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20)
                   | (imm & 32'h000F_F000)
                   | (32'(rd) << 7) | 32'(opcode);
                re = !fits(imm, 21) || imm[0];
            end
            default: begin
                w  = 32'h0000_0013;
                fe = 1'b1;
            end
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_addr  = BASE;
        m_re    = 1'b0;
        m_fe    = 1'b0;
        m_count = 0;
        m_next  = BASE;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("full", 32'(full), 32'(m_count == MAXW));
        if (m_valid) begin
            chk("instr", instr, m_instr);
            chk("addr", addr, m_addr);
            chk("range_err", 32'(range_err), 32'(m_re));
            chk("fmt_err", 32'(fmt_err), 32'(m_fe));
        end
    endtask

    // inputs are set at a negedge; returns at the following negedge
    task automatic tick();
        logic rdy;
        logic acc;
        logic re;
        logic fe;
        logic [31:0] w;
        #1;
        rdy = !restart && (m_count != MAXW) && (!m_valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        w = model_enc(re, fe);
        if (acc) begin
            m_valid = 1'b1;
            m_instr = w;
            m_addr  = m_next;
            m_re    = re;
            m_fe    = fe;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (restart) begin
            m_count = 0;
            m_next  = BASE;
        end else if (acc) begin
            m_count++;
            m_next = m_next + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst instr", instr, 32'h0);
        chk("rst addr", addr, BASE);
        chk("rst range_err", 32'(range_err), 32'd0);
        chk("rst fmt_err", 32'(fmt_err), 32'd0);
        chk("rst full", 32'(full), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [2:0] f3, input logic [31:0] im);
        opcode = op;
        rd     = d;
        rs1    = s1;
        rs2    = s2;
        funct3 = f3;
        funct7 = 7'h0;
        imm    = im;
    endtask

    logic [6:0] ops [9] = '{7'b0110011, 7'b0000011, 7'b0010011,
                            7'b1100111, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111};

    task automatic rand_fields();
        if ($urandom_range(0, 4) == 0)
            opcode = 7'($urandom);
        else
            opcode = ops[$urandom_range(0, 8)];
        rd     = 5'($urandom);
        rs1    = 5'($urandom);
        rs2    = 5'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: imm = $urandom;
            2: imm = (32'($urandom_range(0, 4194303)) - 32'd2097152)
                   & ~32'h1;
            default: imm = $urandom & 32'hFFFF_F000;
        endcase
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        restart   = 1'b0;
        set_fields(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        model_reset();
        @(negedge clk);
        do_reset();
        #1;
        chk("ready after reset", 32'(in_ready), 32'd1);

        // addi x1, x0, 5
        set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        in_valid = 1'b1;
        tick();
        chk("addi instr", instr, 32'h0050_0093);
        chk("addi addr", addr, 32'h0);
        chk("addi valid", 32'(out_valid), 32'd1);
        chk("addi errs", {30'd0, range_err, fmt_err}, 32'd0);

        // sw x2, 8(x1)
        set_fields(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 32'd8);
        tick();
        chk("sw instr", instr, 32'h0020_A423);
        chk("sw addr", addr, 32'h4);

        set_fields(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        tick();
        chk("beq -4 instr", instr, 32'hFE00_0EE3);
        chk("beq -4 range", 32'(range_err), 32'd0);

        in_valid = 1'b0;
        restart  = 1'b1;
        tick();
        restart  = 1'b0;
        in_valid = 1'b1;

        set_fields(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4096);
        tick();
        chk("beq 4096 range", 32'(range_err), 32'd1);
        set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096);
        tick();
        chk("addi 4096 instr", instr, 32'h0000_0093);
        chk("addi 4096 range", 32'(range_err), 32'd1);
        set_fields(7'b1111111, 5'd3, 5'd4, 5'd5, 3'd1, 32'd7);
        tick();
        chk("bad op instr", instr, 32'h0000_0013);
        chk("bad op fmt", 32'(fmt_err), 32'd1);
        chk("bad op range", 32'(range_err), 32'd0);

        in_valid = 1'b0;
        restart  = 1'b1;
        tick();
        restart  = 1'b0;

        // back-pressure then streaming
        set_fields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall ready", 32'(in_ready), 32'd0);
            chk("stall instr", instr, 32'h0050_0093);
            chk("stall addr", addr, 32'h0);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("stream valid", 32'(out_valid), 32'd1);
            chk("stream addr", addr, 32'(4 * i));
        end
        chk("full set", 32'(full), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("full blocks", 32'(in_ready), 32'd0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart clears full", 32'(full), 32'd0);
        chk("restart keeps word", 32'(out_valid), 32'd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("restart addr", addr, BASE);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            rand_fields();
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            restart   = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 299) == 0)
                do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
